// File: rtl/y_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : y_chk_pkg
// Brief   : Shared FSM state type and default MISR constants for the checker.
// Revision: 1.0
// ============================================================================
package y_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] POLY_DEFAULT = 32'h04C1_1DB7;
    localparam logic [31:0] SEED_DEFAULT = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/y_misr_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : y_misr_checker_if
// Brief   : Capture/result bundle between a stimulus source and the checker.
// Revision: 1.0
// ============================================================================
interface y_misr_checker_if #(
    parameter int Y_W   = 119,
    parameter int SIG_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             y_valid;
    logic [Y_W-1:0]   y;
    logic [CNT_W-1:0] exp_count;
    logic [SIG_W-1:0] exp_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] sample_cnt;
    logic             late;

    modport master (
        output start, y_valid, y, exp_count, exp_sig,
        input  busy, done, pass, sig, sample_cnt, late
    );

    modport slave (
        input  start, y_valid, y, exp_count, exp_sig,
        output busy, done, pass, sig, sample_cnt, late
    );
endinterface
`default_nettype wire

// File: rtl/misr_step.sv
`default_nettype none
// ============================================================================
// Module  : misr_step
// Brief   : Folds a wide sample into SIG_W bits and applies one MISR shift.
// Revision: 1.0
// ============================================================================
module misr_step
    import y_chk_pkg::*;
#(
    parameter int               Y_W   = 119,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
    input  wire logic [SIG_W-1:0] sig_i,
    input  wire logic [Y_W-1:0]   y_i,
    output logic      [SIG_W-1:0] sig_next_o
);
    localparam int c_N_SLICE = (Y_W + SIG_W - 1) / SIG_W;

    logic [c_N_SLICE*SIG_W-1:0] w_y_pad;
    logic [SIG_W-1:0]           w_fold;

    // Zero-extension pads the top slice when Y_W is not a multiple of SIG_W.
    assign w_y_pad = (c_N_SLICE*SIG_W)'(y_i);

    always_comb begin
        w_fold = '0;
        for (int i = 0; i < c_N_SLICE; i++) begin
            w_fold = w_fold ^ w_y_pad[i*SIG_W +: SIG_W];
        end
    end

    assign sig_next_o = {sig_i[SIG_W-2:0], 1'b0}
                      ^ (sig_i[SIG_W-1] ? POLY : '0)
                      ^ w_fold;
endmodule
`default_nettype wire

// File: rtl/y_misr_checker.sv
`default_nettype none
// ============================================================================
// Module  : y_misr_checker
// Brief   : Compresses qualified DUT output words into a MISR signature and
//           compares it against a golden value after a programmed sample count.
// Revision: 1.0
// ============================================================================
module y_misr_checker
    import y_chk_pkg::*;
#(
    parameter int               Y_W   = 119,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEFAULT),
    parameter int               CNT_W = 16
) (
    input wire logic         clk,
    input wire logic         rst_n,
    y_misr_checker_if.slave  bus
);
    state_t           state_q,   state_d;
    logic [SIG_W-1:0] sig_q,     sig_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] exp_cnt_q, exp_cnt_d;
    logic [SIG_W-1:0] exp_sig_q, exp_sig_d;
    logic             pass_q,    pass_d;
    logic             late_q,    late_d;

    logic [SIG_W-1:0] w_sig_next;
    logic [CNT_W-1:0] w_cnt_inc;

    misr_step #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr_step (
        .sig_i      (sig_q),
        .y_i        (bus.y),
        .sig_next_o (w_sig_next)
    );

    assign w_cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sig_q     <= '0;
            cnt_q     <= '0;
            exp_cnt_q <= '0;
            exp_sig_q <= '0;
            pass_q    <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            exp_cnt_q <= exp_cnt_d;
            exp_sig_q <= exp_sig_d;
            pass_q    <= pass_d;
            late_q    <= late_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        exp_cnt_d = exp_cnt_q;
        exp_sig_d = exp_sig_q;
        pass_d    = pass_q;
        late_d    = late_q;

        // start overrides everything, including a coincident y_valid.
        if (bus.start) begin
            sig_d     = SEED;
            cnt_d     = '0;
            late_d    = 1'b0;
            exp_cnt_d = bus.exp_count;
            exp_sig_d = bus.exp_sig;
            if (bus.exp_count == '0) begin
                state_d = ST_DONE;
                pass_d  = (SEED == bus.exp_sig);
            end else begin
                state_d = ST_RUN;
                pass_d  = 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.y_valid) begin
                        sig_d = w_sig_next;
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == exp_cnt_q) begin
                            state_d = ST_DONE;
                            pass_d  = (w_sig_next == exp_sig_q);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.y_valid) begin
                        late_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pass       = (state_q == ST_DONE) && pass_q;
    assign bus.sig        = sig_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.late       = late_q;
endmodule
`default_nettype wire

// File: tb/tb_y_misr_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_y_misr_checker
// Brief   : Directed and randomized self-checking bench for y_misr_checker.
// Revision: 1.0
// ============================================================================
module tb_y_misr_checker;
    localparam int          c_YW   = 119;
    localparam int          c_SW   = 32;
    localparam int          c_CW   = 16;
    localparam logic [31:0] c_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] c_SEED = 32'hFFFF_FFFF;
    localparam int          c_IDLE = 0, c_RUN = 1, c_DONE = 2;

    logic clk;
    logic rst_n;

    y_misr_checker_if #(.Y_W(c_YW), .SIG_W(c_SW), .CNT_W(c_CW)) bus ();

    y_misr_checker #(
        .Y_W   (c_YW),
        .SIG_W (c_SW),
        .POLY  (c_POLY),
        .SEED  (c_SEED),
        .CNT_W (c_CW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          m_state;
    logic [31:0] m_sig;
    int          m_cnt;
    int          m_exp;
    logic [31:0] m_esig;
    bit          m_pass;
    bit          m_late;
    logic [118:0] vec [29];

    // Signature update as multiplication by x modulo x^32 + POLY, plus the
    // sample folded bit-by-bit onto position (bit index mod 32).
    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [118:0] yy);
        logic [32:0] p;
        logic [31:0] f;
        f = '0;
        for (int b = 0; b < c_YW; b++) f[b % 32] = f[b % 32] ^ yy[b];
        p = {s, 1'b0};
        if (p[32]) p = p ^ {1'b1, c_POLY};
        return p[31:0] ^ f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 64'(bus.busy),       64'(m_state == c_RUN));
        chk({tag, ".done"}, 64'(bus.done),       64'(m_state == c_DONE));
        chk({tag, ".pass"}, 64'(bus.pass),       64'((m_state == c_DONE) && m_pass));
        chk({tag, ".sig"},  64'(bus.sig),        64'(m_sig));
        chk({tag, ".cnt"},  64'(bus.sample_cnt), 64'(m_cnt));
        chk({tag, ".late"}, 64'(bus.late),       64'(m_late));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cnt, input logic [31:0] es, input bit yv, input logic [118:0] yy);
        bus.start     = 1'b1;
        bus.exp_count = 16'(cnt);
        bus.exp_sig   = es;
        bus.y_valid   = yv;
        bus.y         = yy;
        cyc();
        bus.start   = 1'b0;
        bus.y_valid = 1'b0;
        m_sig  = c_SEED;
        m_cnt  = 0;
        m_exp  = cnt;
        m_esig = es;
        m_late = 1'b0;
        if (cnt == 0) begin
            m_state = c_DONE;
            m_pass  = (c_SEED == es);
        end else begin
            m_state = c_RUN;
            m_pass  = 1'b0;
        end
    endtask

    task automatic send(input logic [118:0] yy, input bit yv);
        bus.y       = yy;
        bus.y_valid = yv;
        cyc();
        bus.y_valid = 1'b0;
        if (yv && m_state == c_RUN) begin
            m_sig = ref_step(m_sig, yy);
            m_cnt++;
            if (m_cnt == m_exp) begin
                m_state = c_DONE;
                m_pass  = (m_sig == m_esig);
            end
        end else if (yv && m_state == c_DONE) begin
            m_late = 1'b1;
        end
    endtask

    initial begin
        logic [31:0]  golden;
        logic [31:0]  held;
        logic [118:0] one;

        bus.start = 1'b0; bus.y_valid = 1'b0; bus.y = '0;
        bus.exp_count = '0; bus.exp_sig = '0;
        m_state = c_IDLE; m_sig = '0; m_cnt = 0; m_exp = 0;
        m_esig = '0; m_pass = 1'b0; m_late = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_all("reset");
        @(negedge clk) rst_n = 1'b1;
        cyc();

        // Zero-length runs
        do_start(0, 32'hFFFF_FFFF, 1'b0, '0);
        check_all("zero_pass");
        chk("zero_pass.const", 64'(bus.pass), 64'd1);
        do_start(0, 32'h0, 1'b0, '0);
        check_all("zero_fail");

        // Single-sample runs, including fold of a bit from the second slice
        do_start(1, 32'h0, 1'b0, '0);
        send('0, 1'b1);
        check_all("single_y0");
        chk("single_y0.const", 64'(bus.sig), 64'h0000_0000_FB3E_E249);
        do_start(1, 32'hFB3E_E248, 1'b0, '0);
        send(119'd1, 1'b1);
        chk("single_y1.const", 64'(bus.sig), 64'h0000_0000_FB3E_E248);
        chk("single_y1.pass",  64'(bus.pass), 64'd1);
        one = 119'd1 << 32;
        do_start(1, 32'h0, 1'b0, '0);
        send(one, 1'b1);
        chk("single_y32.const", 64'(bus.sig), 64'h0000_0000_FB3E_E248);

        // 29 random vectors with random gaps
        golden = c_SEED;
        for (int i = 0; i < 29; i++) begin
            vec[i]  = 119'({$urandom(), $urandom(), $urandom(), $urandom()});
            golden  = ref_step(golden, vec[i]);
        end
        do_start(29, golden, 1'b0, '0);
        for (int i = 0; i < 29; i++) begin
            if ($urandom_range(0, 1) == 1) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b0);
            send(vec[i], 1'b1);
        end
        check_all("multi");
        chk("multi.pass_const", 64'(bus.pass), 64'd1);
        chk("multi.cnt_const",  64'(bus.sample_cnt), 64'd29);
        vec[7][118] = ~vec[7][118];
        do_start(29, golden, 1'b0, '0);
        for (int i = 0; i < 29; i++) send(vec[i], 1'b1);
        check_all("multi_flip");
        chk("multi_flip.pass_const", 64'(bus.pass), 64'd0);

        // Gap mid-run, then late samples in DONE
        do_start(6, 32'h1234_5678, 1'b0, '0);
        for (int i = 0; i < 3; i++) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        held = m_sig;
        for (int i = 0; i < 3; i++) begin
            send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b0);
            chk("gap.sig_held", 64'(bus.sig), 64'(held));
        end
        for (int i = 0; i < 3; i++) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        check_all("gap_done");
        held = m_sig;
        send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        check_all("late");
        chk("late.sig_held", 64'(bus.sig), 64'(held));
        chk("late.flag",     64'(bus.late), 64'd1);

        // Asynchronous reset in the middle of a run
        do_start(10, 32'h0, 1'b0, '0);
        for (int i = 0; i < 5; i++) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        #2 rst_n = 1'b0;
        m_state = c_IDLE; m_sig = '0; m_cnt = 0; m_pass = 1'b0; m_late = 1'b0;
        #1 check_all("async_rst");
        #3 rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        check_all("post_rst_idle");

        // start coinciding with y_valid in RUN reseeds without accumulating
        do_start(10, 32'h0, 1'b0, '0);
        for (int i = 0; i < 3; i++) send(119'({$urandom(), $urandom(), $urandom(), $urandom()}), 1'b1);
        do_start(10, 32'h0, 1'b1, 119'({$urandom(), $urandom(), $urandom(), $urandom()}));
        check_all("restart");
        chk("restart.sig_const", 64'(bus.sig), 64'h0000_0000_FFFF_FFFF);
        chk("restart.cnt_const", 64'(bus.sample_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/y_misr_checker.md
Y_MISR_CHECKER -- requirements
Module: y_misr_checker

Interface
REQ-001 Parameter Y_W, default 119, SHALL set the width of the captured DUT output bus y.
REQ-002 Parameter SIG_W, default 32, SHALL set the signature width.
REQ-003 Parameter POLY, default 32'h04C11DB7, SHALL set the MISR feedback polynomial.
REQ-004 Parameter SEED, default 32'hFFFFFFFF, SHALL set the signature value loaded on start.
REQ-005 Parameter CNT_W, default 16, SHALL set the sample-counter width.
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 start  input  1  SHALL be a one-cycle pulse that begins a capture run.
REQ-009 y_valid  input  1  SHALL qualify y as a sample in the current cycle.
REQ-010 y  input  Y_W  SHALL carry the DUT output word to compress.
REQ-011 exp_count  input  CNT_W  SHALL give the number of samples in a run, sampled on start.
REQ-012 exp_sig  input  SIG_W  SHALL give the golden signature, sampled on start.
REQ-013 busy  output  1  SHALL be high while in RUN.
REQ-014 done  output  1  SHALL be high while in DONE.
REQ-015 pass  output  1  SHALL be high in DONE when the final signature equals the latched exp_sig.
REQ-016 sig  output  SIG_W  SHALL present the current signature register.
REQ-017 sample_cnt  output  CNT_W  SHALL present the number of samples accepted in the current run.
REQ-018 late  output  1  SHALL be a sticky flag: y_valid seen while in DONE.

Function
REQ-019 fold(y) SHALL be the XOR of consecutive SIG_W-bit slices of y, starting at bit 0, with the top slice zero-padded (119 -> 3 full slices plus 23 bits).
REQ-020 Per accepted sample: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(y).
REQ-021 FSM states SHALL be IDLE, RUN and DONE.
REQ-022 start in any state SHALL load sig=SEED, sample_cnt=0, clear late, and latch exp_count and exp_sig.
REQ-023 After start, the next state SHALL be RUN, or DONE if exp_count=0.
REQ-024 In RUN, y_valid=1 SHALL update sig and increment sample_cnt in the same edge.
REQ-025 The edge that makes sample_cnt equal the latched exp_count SHALL move the FSM to DONE; done and pass SHALL be valid in the following cycle, i.e. 1 cycle after the final sample.
REQ-026 pass SHALL be computed on the final sig_next, and for exp_count=0 on SEED.
REQ-027 y_valid in IDLE SHALL be ignored; y_valid in DONE SHALL be ignored and SHALL set late.
REQ-028 start coinciding with y_valid SHALL reseed; that y SHALL NOT be accumulated.
REQ-029 DONE SHALL persist until start or reset; sig and sample_cnt SHALL hold in DONE.
REQ-030 sample_cnt SHALL never wrap, because RUN ends at exp_count <= 2^CNT_W-1.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, busy=0, done=0, pass=0, late=0, sig=0, sample_cnt=0, regardless of clk.
REQ-032 Reset asserted mid-RUN SHALL discard the run; no done pulse SHALL follow the release of reset.
REQ-033 Reset release SHALL be synchronised externally; the block SHALL require no start until the first edge after release.

Structure
REQ-034 The state enum and the POLY/SEED default constants SHALL reside in a shared package, y_chk_pkg.
REQ-035 The fold and MISR step SHALL form one combinational sub-module, misr_step, parameterised by Y_W, SIG_W and POLY; the FSM and registers SHALL stay in the top module.

Verification
REQ-036 Zero-length run: exp_count=0, exp_sig=FFFFFFFF, start -> done=1 and pass=1 one cycle later; with exp_sig=0 -> pass=0.
REQ-037 Single sample: exp_count=1, y=0 -> sig=FB3EE249, done the next cycle; with y=1 or y=1<<32, sig=FB3EE248 (checks folding).
REQ-038 Multi-sample run: drive 29 vectors with y_valid, set exp_sig to the reference-model value -> pass=1 and sample_cnt=29; flipping y bit 118 in one vector -> pass=0.
REQ-039 Gaps and late samples: hold y_valid low for 3 cycles mid-run -> sig unchanged during the gap; y_valid in DONE -> late=1 and sig held.
REQ-040 Reset mid-RUN: after 5 of 10 samples, pulse rst_n low between clock edges -> all outputs 0 immediately, IDLE, and no done afterwards.
REQ-041 Restart: start asserted in RUN together with y_valid -> sig=FFFFFFFF and sample_cnt=0 on the next edge.
